// File: rtl/alu_iter_exec_if.sv
// Operand/result handshake bundle for the iterative execute-stage ALU.
// The slave modport is the ALU's view; master is the issuing/consuming side.
interface alu_iter_exec_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport slave (
    input  in_valid, ALUCtrl, src_a, src_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );

  modport master (
    output in_valid, ALUCtrl, src_a, src_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU: single-cycle logic/arith/compare, one-bit-per-cycle shifts.
// One operation in flight; result held in DONE until the consumer accepts it.
module alu_iter_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_iter_exec_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101
  } op_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             slt_w;

  assign slt_w = ($signed(bus.src_a) < $signed(bus.src_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      result_q  <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
    end
  end

  // The result register doubles as the shift working register; it is not
  // visible as valid until DONE, so intermediate values are never exposed.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          illegal_d = 1'b0;
          state_d   = DONE;
          case (bus.ALUCtrl)
            OP_AND: result_d = bus.src_a & bus.src_b;
            OP_OR:  result_d = bus.src_a | bus.src_b;
            OP_ADD: result_d = bus.src_a + bus.src_b;
            OP_SUB: result_d = bus.src_a - bus.src_b;
            OP_SLT: result_d = {{(WIDTH-1){1'b0}}, slt_w};
            OP_SLL, OP_SRL: begin
              result_d = bus.src_b;
              cnt_d    = bus.shamt;
              left_d   = (bus.ALUCtrl == OP_SLL);
              if (bus.shamt != 5'd0) state_d = SHIFT;
            end
            default: begin
              result_d  = '0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      SHIFT: begin
        result_d = left_q ? (result_q << 1) : (result_q >> 1);
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: driver pushes expected results, monitor pops on handshake.
module tb_alu_iter_exec;

  logic clk;
  logic rst_n;

  alu_iter_exec_if #(.WIDTH(32)) bus ();

  alu_iter_exec #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each accepted result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got result %h with no expected entry", bus.result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("mon_result",  bus.result,         e.res);
        chk("mon_zero",    32'(bus.zero),      32'(e.res == 32'h0));
        chk("mon_illegal", 32'(bus.illegal),   32'(e.ill));
      end
    end
  end

  // Issue one op; optionally push its expectation and measure edges to out_valid.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp_res, input logic exp_ill,
                       input int exp_edges, input bit expect_it);
    int n;
    int edges;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 32'(bus.in_ready), 32'd1);
    if (expect_it) begin
      e.res = exp_res;
      e.ill = exp_ill;
      sb_q.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.ALUCtrl  = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.shamt    = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    bus.shamt    = 5'($urandom);
    bus.ALUCtrl  = 4'($urandom);
    if (expect_it) begin
      edges = 0;
      @(negedge clk);
      while (!bus.out_valid && edges < 64) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
      chk("latency", 32'(edges), 32'(exp_edges));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.ALUCtrl   = 4'h0;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.shamt     = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result",    bus.result,         32'h0);
    chk("rst_zero",      32'(bus.zero),      32'd1);
    chk("rst_illegal",   32'(bus.illegal),   32'd0);
    rst_n = 1'b1;

    // op, a, b, shamt, expected result, expected illegal, edges to out_valid
    issue(4'b0010, 32'd5,        32'd7,        5'd0,  32'd12,        1'b0, 0, 1);
    issue(4'b0110, 32'h3,        32'h3,        5'd0,  32'h0,         1'b0, 0, 1);
    issue(4'b0110, 32'h0,        32'h1,        5'd0,  32'hFFFF_FFFF, 1'b0, 0, 1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'h1,       5'd0,  32'h1,         1'b0, 0, 1);
    issue(4'b0111, 32'h1,        32'hFFFF_FFFF, 5'd0, 32'h0,         1'b0, 0, 1);
    issue(4'b0001, 32'hF0,       32'h0F,       5'd0,  32'hFF,        1'b0, 0, 1);
    issue(4'b0010, 32'hFFFF_FFFF, 32'h2,       5'd0,  32'h1,         1'b0, 0, 1);
    issue(4'b0100, 32'hDEAD_BEEF, 32'h1,       5'd31, 32'h8000_0000, 1'b0, 31, 1);
    issue(4'b0101, 32'h1234_5678, 32'h8000_0000, 5'd0, 32'h8000_0000, 1'b0, 0, 1);
    issue(4'b0101, 32'h0,        32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 4, 1);
    issue(4'b0100, 32'h0,        32'h0000_00F1, 5'd3, 32'h0000_0788, 1'b0, 3, 1);
    issue(4'b0101, 32'h0,        32'hA5A5_A5A5, 5'd1, 32'h52D2_D2D2, 1'b0, 1, 1);
    issue(4'b0011, 32'h55,       32'hAA,       5'd0,  32'h0,         1'b1, 0, 1);

    // Backpressure: hold DONE for 3 cycles while pulsing a competing op.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    issue(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0F00_0F00, 1'b0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.ALUCtrl  = 4'b0010;
      bus.src_a    = 32'd100;
      bus.src_b    = 32'd200;
      @(negedge clk);
      chk("bp_result",    bus.result,          32'h0F00_0F00);
      chk("bp_out_valid", 32'(bus.out_valid),  32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),   32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of a long shift discards it.
    issue(4'b0100, 32'h0, 32'h0000_0003, 5'd20, 32'h0, 1'b0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_result",    bus.result,         32'h0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_zero",      32'(bus.zero),      32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'b1111, 32'h1234, 32'h5678, 5'd7, 32'h0,  1'b1, 0, 1);
    issue(4'b0010, 32'd40,   32'd2,    5'd0, 32'd42, 1'b0, 0, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
